char_glyph_fetch: RTL and testbench

- Parametrised, single-clock successor to the text-mode character bitmap RAM.
- Holds the font glyph store as a byte-wide block RAM with a CPU write port.
- Runs a req/valid fetch engine that computes the glyph-row address from character code, scanline, glyph height and bytes-per-row, then gathers a variable-width row bitmap.
- Sits between the text controller's character-code pipeline and the pixel shifter.

---
 rtl/char_glyph_fetch.sv | 135 +++++++++++++
 tb/tb_char_glyph_fetch.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_glyph_fetch.sv
// Font glyph store with a CPU write port and a req/valid glyph-row fetch engine.
// Define CHAR_GLYPH_READBACK_EN to let the CPU port read the glyph store back on dat_o.
module char_glyph_fetch #(
  parameter int ADDR_W  = 15,
  parameter int MAX_BPR = 8,
  parameter int CODE_W  = 20
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cs_i,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    adr_i,
  input  logic [7:0]           dat_i,
  output logic [7:0]           dat_o,
  output logic                 ack_o,
  input  logic [ADDR_W-1:0]    font_base_i,
  input  logic [3:0]           bpr_i,
  input  logic [5:0]           lines_i,
  input  logic                 req_i,
  input  logic [CODE_W-1:0]    char_code_i,
  input  logic [5:0]           scanline_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [8*MAX_BPR-1:0] bmp_o
);

  localparam int         ROW_W     = CODE_W + 7;
  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0] MAX_BPR_C = 4'(MAX_BPR);

  typedef enum logic [1:0] {IDLE, CALC, FETCH, DONE} state_t;

  state_t                      state;
  logic [7:0]                  mem [DEPTH];
  logic [7:0]                  rd_b;
  logic [ADDR_W-1:0]           rd_addr;
  logic [3:0]                  eff_bpr;
  logic [ROW_W-1:0]            row;

  logic [CODE_W-1:0]           code_q;
  logic [5:0]                  scan_q;
  logic [5:0]                  lines_q;
  logic [ADDR_W-1:0]           base_q;
  logic [3:0]                  bpr_q;
  logic [ADDR_W-1:0]           addr_q;
  logic [3:0]                  cnt;
  logic [MAX_BPR-1:0][7:0]     shadow;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    eff_bpr = bpr_i;
    if (bpr_i == 4'd0)            eff_bpr = 4'd1;
    else if (bpr_i > MAX_BPR_C)   eff_bpr = MAX_BPR_C;
  end

  assign row     = ROW_W'(code_q) * ROW_W'(lines_q) + ROW_W'(scan_q);
  assign rd_addr = addr_q + ADDR_W'(cnt);

  // NOTE: the glyph store and its read register carry no reset; font contents must survive a reset.
  // Reads and writes share one edge with non-blocking updates, so a colliding read sees the old byte.
  always_ff @(posedge clk_i) begin
    if (cs_i && we_i) mem[adr_i] <= dat_i;
    rd_b <= mem[rd_addr];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ack_o <= 1'b0;
    else         ack_o <= cs_i;
  end

`ifdef CHAR_GLYPH_READBACK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               dat_o <= 8'h00;
    else if (cs_i && !we_i)    dat_o <= mem[adr_i];
  end
`else
  assign dat_o = 8'h00;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      bmp_o   <= '0;
      code_q  <= '0;
      scan_q  <= '0;
      lines_q <= '0;
      base_q  <= '0;
      bpr_q   <= 4'd1;
      addr_q  <= '0;
      cnt     <= '0;
      shadow  <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          // busy_o stays high through the valid cycle because DONE leaves it set
          if (req_i) begin
            code_q  <= char_code_i;
            scan_q  <= scanline_i;
            lines_q <= lines_i;
            base_q  <= font_base_i;
            bpr_q   <= eff_bpr;
            cnt     <= '0;
            shadow  <= '0;
            busy_o  <= 1'b1;
            state   <= CALC;
          end else begin
            busy_o  <= 1'b0;
          end
        end
        CALC: begin
          addr_q <= base_q + ADDR_W'(row * ROW_W'(bpr_q));
          state  <= FETCH;
        end
        FETCH: begin
          // read for byte cnt is issued this edge; byte cnt-1 lands now
          for (int b = 0; b < MAX_BPR; b++) begin
            if (cnt == 4'(b + 1)) shadow[MAX_BPR-1-b] <= rd_b;
          end
          if (cnt == bpr_q) state <= DONE;
          else              cnt   <= cnt + 4'd1;
        end
        DONE: begin
          bmp_o   <= shadow;
          valid_o <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_glyph_fetch.sv
// Scoreboard bench for char_glyph_fetch: expected rows and their due cycle are queued at request time.
module tb_char_glyph_fetch;

  localparam logic [7:0] EXP_RD =
`ifdef CHAR_GLYPH_READBACK_EN
    8'h5A;
`else
    8'h00;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cs_i, we_i;
  logic [14:0] adr_i;
  logic [7:0]  dat_i, dat_o;
  logic        ack_o;
  logic [14:0] font_base_i;
  logic [3:0]  bpr_i;
  logic [5:0]  lines_i;
  logic        req_i;
  logic [19:0] char_code_i;
  logic [5:0]  scanline_i;
  logic        busy_o, valid_o;
  logic [63:0] bmp_o;

  typedef struct {
    logic [63:0] bmp;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  char_glyph_fetch dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cs_i(cs_i), .we_i(we_i), .adr_i(adr_i),
    .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .font_base_i(font_base_i),
    .bpr_i(bpr_i), .lines_i(lines_i), .req_i(req_i), .char_code_i(char_code_i),
    .scanline_i(scanline_i), .busy_o(busy_o), .valid_o(valid_o), .bmp_o(bmp_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Every valid_o must match the oldest outstanding row, both in data and in arrival cycle.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: bmp_o=%h at cycle %0d, no row outstanding", bmp_o, cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bmp_o !== e.bmp) begin
          errors++;
          $display("FAIL row_data: bmp_o=%h, expected %h", bmp_o, e.bmp);
        end
        checks++;
        if (cyc !== e.cyc) begin
          errors++;
          $display("FAIL row_latency: valid at cycle %0d, expected cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cpu_write(input logic [14:0] a, input logic [7:0] d);
    @(negedge clk_i);
    cs_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d;
    @(negedge clk_i);
    cs_i = 1'b0; we_i = 1'b0;
  endtask

  // Drives a one-cycle request from IDLE; the row is due eff_bpr+3 edges after the accept edge.
  task automatic issue(input logic [14:0] base, input logic [3:0] bpr, input logic [5:0] lines,
                       input logic [19:0] code, input logic [5:0] scan,
                       input logic [63:0] exp_bmp, input int eb);
    @(negedge clk_i);
    font_base_i = base; bpr_i = bpr; lines_i = lines; char_code_i = code; scanline_i = scan;
    req_i = 1'b1;
    sb.push_back('{bmp: exp_bmp, cyc: cyc + 1 + eb + 3});
    @(negedge clk_i);
    req_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d rows still pending, expected 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({busy_o, valid_o, ack_o} !== 3'b000 || bmp_o !== 64'h0 || dat_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: busy=%b valid=%b ack=%b bmp=%h dat=%h, expected all 0",
               busy_o, valid_o, ack_o, bmp_o, dat_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    cpu_write(15'h0100, 8'hA5);
    issue(15'h0100, 4'd1, 6'd18, 20'd0, 6'd0, 64'hA500_0000_0000_0000, 1);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy_o=%b after accept, expected 1", busy_o);
    end
    drain("basic");
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: busy_o=%b after row, expected 0", busy_o);
    end
  endtask

  task automatic test_multi_byte();
    cpu_write(15'h1076, 8'h12);
    cpu_write(15'h1077, 8'h34);
    issue(15'h1000, 4'd2, 6'd18, 20'd3, 6'd5, 64'h1234_0000_0000_0000, 2);
    drain("multi");
  endtask

  task automatic test_wrap_clamp();
    logic [14:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 15'h7FFE + 15'(i);
      cpu_write(a, 8'(8'h11 * (i + 1)));
    end
    issue(15'h7FFE, 4'd9, 6'd18, 20'd0, 6'd0, 64'h1122_3344_5566_7788, 8);
    drain("clamp_hi");
    issue(15'h7FFE, 4'd0, 6'd18, 20'd0, 6'd0, 64'h1100_0000_0000_0000, 1);
    drain("clamp_lo");
  endtask

  task automatic test_busy_reject();
    int a;
    cpu_write(15'h2008, 8'hC3);
    cpu_write(15'h2010, 8'h3C);
    issue(15'h2000, 4'd1, 6'd8, 20'd1, 6'd0, 64'hC300_0000_0000_0000, 1);
    @(negedge clk_i);
    char_code_i = 20'd2;
    req_i = 1'b1;
    @(negedge clk_i);
    req_i = 1'b0;
    drain("reject");
    repeat (6) @(negedge clk_i);

    // held request: second accept must land on the edge closing the valid cycle
    @(negedge clk_i);
    char_code_i = 20'd1;
    req_i = 1'b1;
    a = cyc + 1;
    sb.push_back('{bmp: 64'hC300_0000_0000_0000, cyc: a + 4});
    sb.push_back('{bmp: 64'h3C00_0000_0000_0000, cyc: a + 9});
    @(negedge clk_i);
    char_code_i = 20'd2;
    repeat (4) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_valid_busy: busy=%b valid=%b in valid cycle, expected 1 1", busy_o, valid_o);
    end
    @(negedge clk_i);
    req_i = 1'b0;
    drain("hold");
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    font_base_i = 15'h7FFE; bpr_i = 4'd8; lines_i = 6'd18; char_code_i = 20'd0; scanline_i = 6'd0;
    req_i = 1'b1;
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || bmp_o !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b valid=%b bmp=%h, expected 0 0 0", busy_o, valid_o, bmp_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (15) @(negedge clk_i);
    issue(15'h7FFE, 4'd8, 6'd18, 20'd0, 6'd0, 64'h1122_3344_5566_7788, 8);
    drain("after_reset");
  endtask

  task automatic test_cpu_port();
    @(negedge clk_i);
    checks++;
    if (ack_o !== 1'b0) begin
      errors++;
      $display("FAIL cpu_ack_idle: ack_o=%b, expected 0", ack_o);
    end
    cs_i = 1'b1; we_i = 1'b1; adr_i = 15'h0042; dat_i = 8'h5A;
    @(negedge clk_i);
    cs_i = 1'b0; we_i = 1'b0;
    checks++;
    if (ack_o !== 1'b1) begin
      errors++;
      $display("FAIL cpu_ack_write: ack_o=%b, expected 1", ack_o);
    end
    @(negedge clk_i);
    cs_i = 1'b1; we_i = 1'b0; adr_i = 15'h0042;
    @(negedge clk_i);
    cs_i = 1'b0;
    checks++;
    if (ack_o !== 1'b1 || dat_o !== EXP_RD) begin
      errors++;
      $display("FAIL cpu_read: ack=%b dat_o=%h, expected 1 %h", ack_o, dat_o, EXP_RD);
    end
    @(negedge clk_i);
    checks++;
    if (ack_o !== 1'b0 || dat_o !== EXP_RD) begin
      errors++;
      $display("FAIL cpu_hold: ack=%b dat_o=%h, expected 0 %h", ack_o, dat_o, EXP_RD);
    end
  endtask

  task automatic test_random();
    logic [14:0] base;
    logic [3:0]  bpr;
    logic [5:0]  lines, scan;
    logic [19:0] code;
    logic [7:0]  d;
    logic [63:0] exp_bmp;
    longint      row;
    int          eb, addr;
    for (int t = 0; t < 6; t++) begin
      base  = 15'($urandom_range(0, 32767));
      bpr   = 4'($urandom_range(0, 10));
      lines = 6'($urandom_range(1, 63));
      scan  = 6'($urandom_range(0, 63));
      code  = 20'($urandom_range(0, 1048575));
      eb    = (bpr == 0) ? 1 : (bpr > 8) ? 8 : int'(bpr);
      row   = longint'(code) * longint'(lines) + longint'(scan);
      addr  = int'((longint'(base) + row * eb) % 32768);
      exp_bmp = 64'h0;
      for (int i = 0; i < eb; i++) begin
        d = 8'($urandom_range(0, 255));
        cpu_write(15'((addr + i) % 32768), d);
        exp_bmp[8*(8-i)-1 -: 8] = d;
      end
      issue(base, bpr, lines, code, scan, exp_bmp, eb);
      drain("random");
    end
  endtask

  initial begin
    cs_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0;
    font_base_i = '0; bpr_i = 4'd1; lines_i = 6'd1; req_i = 1'b0;
    char_code_i = '0; scanline_i = '0;
    test_reset();
    test_basic();
    test_multi_byte();
    test_wrap_clamp();
    test_busy_reject();
    test_reset_mid();
    test_cpu_port();
    test_random();
    repeat (5) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
